// File: rtl/evr_timestamp_sequencer_pkg.sv
// Shared types and constants for the EVR timestamp sequencer.
// Event codes, FSM state encoding and datapath widths.
package evr_ts_pkg;

    localparam int TS_W     = 64;
    localparam int SEC_W    = 32;
    localparam int BITCNT_W = 6;

    localparam logic [7:0] EVT_SHIFT0  = 8'h70;
    localparam logic [7:0] EVT_SHIFT1  = 8'h71;
    localparam logic [7:0] EVT_SECONDS = 8'h7D;

    typedef enum logic [1:0] {
        UNSYNC   = 2'd0,
        SYNCED   = 2'd1,
        HOLDOVER = 2'd2
    } ts_state_e;

endpackage

// File: rtl/evr_timestamp_sequencer_if.sv
// Event/latch/timestamp bundle of the EVR timestamp sequencer.
// master: event source + latch requester; slave: the sequencer.
interface evr_timestamp_sequencer_if;
    import evr_ts_pkg::*;

    logic [7:0]      EventCode;
    logic            EventValid;
    logic            LatchReq;
    logic            LatchAck;
    logic [TS_W-1:0] LatchedTs;
    logic [TS_W-1:0] TimeStamp;
    logic            TsValid;
    logic            Holdover;
    logic            ShiftErr;
    logic            ErrClear;

    modport master (
        output EventCode, EventValid, LatchReq, ErrClear,
        input  LatchAck, LatchedTs, TimeStamp, TsValid, Holdover, ShiftErr
    );

    modport slave (
        input  EventCode, EventValid, LatchReq, ErrClear,
        output LatchAck, LatchedTs, TimeStamp, TsValid, Holdover, ShiftErr
    );

endinterface

// File: rtl/evr_ts_seconds_shifter.sv
// Serial seconds shifter: MSB-first bits from 0x70/0x71 events.
// Ports: i_shift/i_bit shift one bit, i_clear on commit; o_shreg, o_count_ok.
module evr_ts_seconds_shifter
    import evr_ts_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_shift,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic [SEC_W-1:0] o_shreg,
    output logic             o_count_ok
);

    localparam logic [BITCNT_W-1:0] CNT_FULL = BITCNT_W'(SEC_W);
    localparam logic [BITCNT_W-1:0] CNT_SAT  = BITCNT_W'(SEC_W + 1);

    logic [SEC_W-1:0]    r_shreg;
    logic [BITCNT_W-1:0] r_bitcnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (i_clear) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[SEC_W-2:0], i_bit};
            // Saturate one past full so over-long loads stay invalid
            if (r_bitcnt != CNT_SAT)
                r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    assign o_shreg    = r_shreg;
    assign o_count_ok = (r_bitcnt == CNT_FULL);

endmodule

// File: rtl/evr_timestamp_sequencer.sv
// EVR 64-bit {seconds, fraction} timestamp sequencer with watchdog and latch.
// Ports: Clock, Reset (async active-low), bus (slave). Macro: EVR_TS_HOLDOVER_EN.
module evr_timestamp_sequencer
    import evr_ts_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = 119000000,
    parameter int unsigned WDOG_MARGIN = 1024
) (
    input  logic Clock,
    input  logic Reset,
    evr_timestamp_sequencer_if.slave bus
);

    localparam logic [31:0] WDOG_LIM = 32'(CLK_PER_SEC + WDOG_MARGIN - 1);
`ifdef EVR_TS_HOLDOVER_EN
    localparam logic [31:0] SEC_LIM  = 32'(CLK_PER_SEC - 1);
    localparam logic [31:0] WDOG_RST = 32'(WDOG_MARGIN);
`endif

    ts_state_e       r_state;
    logic [31:0]     r_sec;
    logic [31:0]     r_frac;
    logic            r_err;
    logic            r_ack;
    logic [TS_W-1:0] r_latched;

    logic             w_evt_shift;
    logic             w_evt_sec;
    logic             w_count_ok;
    logic [SEC_W-1:0] w_shreg;

    assign w_evt_shift = bus.EventValid &&
        (bus.EventCode == EVT_SHIFT0 || bus.EventCode == EVT_SHIFT1);
    assign w_evt_sec = bus.EventValid && (bus.EventCode == EVT_SECONDS);

    evr_ts_seconds_shifter u_shifter (
        .i_clk      (Clock),
        .i_rst_n    (Reset),
        .i_shift    (w_evt_shift),
        .i_bit      (bus.EventCode == EVT_SHIFT1),
        .i_clear    (w_evt_sec),
        .o_shreg    (w_shreg),
        .o_count_ok (w_count_ok)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= UNSYNC;
            r_sec     <= '0;
            r_frac    <= '0;
            r_err     <= 1'b0;
            r_ack     <= 1'b0;
            r_latched <= '0;
        end else begin
            if (w_evt_sec) begin
                r_frac <= '0;
                if (w_count_ok) begin
                    r_sec   <= w_shreg;
                    r_state <= SYNCED;
                end else if (r_state != UNSYNC) begin
                    r_sec <= r_sec + 32'd1;
                end
            end else if (r_state == SYNCED && r_frac == WDOG_LIM) begin
`ifdef EVR_TS_HOLDOVER_EN
                // Margin cycles already elapsed in the new second
                r_sec   <= r_sec + 32'd1;
                r_frac  <= WDOG_RST;
                r_state <= HOLDOVER;
`else
                r_sec   <= '0;
                r_frac  <= r_frac + 32'd1;
                r_state <= UNSYNC;
`endif
            end
`ifdef EVR_TS_HOLDOVER_EN
            else if (r_state == HOLDOVER && r_frac == SEC_LIM) begin
                r_sec  <= r_sec + 32'd1;
                r_frac <= '0;
            end
`endif
            else begin
                r_frac <= r_frac + 32'd1;
            end

            if (w_evt_sec && !w_count_ok)
                r_err <= 1'b1;
            else if (bus.ErrClear)
                r_err <= 1'b0;

            // Capture the pre-update value so a same-cycle event is excluded
            if (bus.LatchReq && !r_ack) begin
                r_latched <= {r_sec, r_frac};
                r_ack     <= 1'b1;
            end else if (!bus.LatchReq) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign bus.TimeStamp = {r_sec, r_frac};
    assign bus.TsValid   = (r_state != UNSYNC);
`ifdef EVR_TS_HOLDOVER_EN
    assign bus.Holdover  = (r_state == HOLDOVER);
`else
    assign bus.Holdover  = 1'b0;
`endif
    assign bus.ShiftErr  = r_err;
    assign bus.LatchAck  = r_ack;
    assign bus.LatchedTs = r_latched;

endmodule

// File: tb/tb_evr_timestamp_sequencer.sv
// Self-checking bench for evr_timestamp_sequencer (CLK_PER_SEC=100, WDOG_MARGIN=8).
// Table-driven latch/event rows plus directed multi-cycle sequences.
module tb_evr_timestamp_sequencer;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    evr_timestamp_sequencer_if bus ();

    evr_timestamp_sequencer #(
        .CLK_PER_SEC (100),
        .WDOG_MARGIN (8)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0]  code;
        logic        valid;
        logic        lreq;
        logic        eclr;
        logic [63:0] ts;
        logic        tsv;
        logic        ho;
        logic        serr;
        logic        ack;
        logic [63:0] lts;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        bus.EventCode  = c;
        bus.EventValid = 1'b1;
        tick();
        bus.EventValid = 1'b0;
        bus.EventCode  = 8'h00;
    endtask

    task automatic shift_in(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < n; i++) begin
            send(t[31] ? 8'h71 : 8'h70);
            t = t << 1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ts"},   bus.TimeStamp, 64'd0);
        chk({tag, "_lts"},  bus.LatchedTs, 64'd0);
        chk({tag, "_ack"},  64'(bus.LatchAck), 64'd0);
        chk({tag, "_tsv"},  64'(bus.TsValid), 64'd0);
        chk({tag, "_ho"},   64'(bus.Holdover), 64'd0);
        chk({tag, "_serr"}, 64'(bus.ShiftErr), 64'd0);
    endtask

    initial begin
        tbl[0] = '{8'h7D, 1, 1, 0, 64'h0000000A_00000000, 1, 0, 0, 1, 64'h00000009_00000042};
        tbl[1] = '{8'h00, 0, 1, 0, 64'h0000000A_00000001, 1, 0, 0, 1, 64'h00000009_00000042};
        tbl[2] = '{8'h00, 0, 0, 0, 64'h0000000A_00000002, 1, 0, 0, 0, 64'h00000009_00000042};
        tbl[3] = '{8'h00, 0, 1, 0, 64'h0000000A_00000003, 1, 0, 0, 1, 64'h0000000A_00000002};
        tbl[4] = '{8'h00, 0, 1, 1, 64'h0000000A_00000004, 1, 0, 0, 1, 64'h0000000A_00000002};
        tbl[5] = '{8'h00, 0, 0, 0, 64'h0000000A_00000005, 1, 0, 0, 0, 64'h0000000A_00000002};
        tbl[6] = '{8'h70, 1, 0, 0, 64'h0000000A_00000006, 1, 0, 0, 0, 64'h0000000A_00000002};
        tbl[7] = '{8'h7D, 1, 0, 0, 64'h0000000B_00000000, 1, 0, 1, 0, 64'h0000000A_00000002};
        tbl[8] = '{8'h00, 0, 0, 1, 64'h0000000B_00000001, 1, 0, 0, 0, 64'h0000000A_00000002};

        bus.EventCode  = 8'h00;
        bus.EventValid = 1'b0;
        bus.LatchReq   = 1'b0;
        bus.ErrClear   = 1'b0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        repeat (2) tick();
        chk_zero("reset");
        Reset = 1'b1;

        // Test 1: load 0x12345678 and commit
        shift_in(32'h12345678, 32);
        chk("t1_pre_tsv", 64'(bus.TsValid), 64'd0);
        send(8'h7D);
        chk("t1_ts", bus.TimeStamp, 64'h12345678_00000000);
        chk("t1_tsv", 64'(bus.TsValid), 64'd1);
        chk("t1_serr", 64'(bus.ShiftErr), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t1_frac", bus.TimeStamp, 64'h12345678_00000000 + 64'(i));
        end

        // Test 2: short load from UNSYNC, clear, set-wins, saturation
        Reset = 1'b0;
        #1 Reset = 1'b1;
        shift_in(32'hFFFFFFFF, 31);
        send(8'h7D);
        chk("t2_serr", 64'(bus.ShiftErr), 64'd1);
        chk("t2_tsv", 64'(bus.TsValid), 64'd0);
        chk("t2_ts", bus.TimeStamp, 64'd0);
        bus.ErrClear = 1'b1;
        tick();
        bus.ErrClear = 1'b0;
        chk("t2_clr", 64'(bus.ShiftErr), 64'd0);
        shift_in(32'h0, 31);
        bus.ErrClear = 1'b1;
        send(8'h7D);
        bus.ErrClear = 1'b0;
        chk("t2_setwins", 64'(bus.ShiftErr), 64'd1);
        bus.ErrClear = 1'b1;
        tick();
        bus.ErrClear = 1'b0;
        chk("t2_clr2", 64'(bus.ShiftErr), 64'd0);
        shift_in(32'h0, 34);
        send(8'h7D);
        chk("t2_sat_serr", 64'(bus.ShiftErr), 64'd1);
        chk("t2_sat_tsv", 64'(bus.TsValid), 64'd0);
        bus.ErrClear = 1'b1;
        tick();
        bus.ErrClear = 1'b0;

        // Test 3: watchdog expiry at seconds 5
        shift_in(32'd5, 32);
        send(8'h7D);
        chk("t3_load", bus.TimeStamp, 64'h00000005_00000000);
        repeat (107) tick();
        chk("t3_pre", bus.TimeStamp, 64'h00000005_0000006B);
        chk("t3_pre_tsv", 64'(bus.TsValid), 64'd1);
        tick();
`ifdef EVR_TS_HOLDOVER_EN
        chk("t3_wd_ts", bus.TimeStamp, 64'h00000006_00000008);
        chk("t3_wd_ho", 64'(bus.Holdover), 64'd1);
        chk("t3_wd_tsv", 64'(bus.TsValid), 64'd1);
        repeat (91) tick();
        chk("t3_ho_pre", bus.TimeStamp, 64'h00000006_00000063);
        tick();
        chk("t3_ho_wrap", bus.TimeStamp, 64'h00000007_00000000);
        chk("t3_ho_ho", 64'(bus.Holdover), 64'd1);
`else
        chk("t3_wd_ts", bus.TimeStamp, 64'h00000000_0000006C);
        chk("t3_wd_tsv", 64'(bus.TsValid), 64'd0);
        chk("t3_wd_ho", 64'(bus.Holdover), 64'd0);
`endif

        // Test 4: valid reload
        shift_in(32'hABCD0000, 32);
        send(8'h7D);
        chk("t4_ts", bus.TimeStamp, 64'hABCD0000_00000000);
        chk("t4_ho", 64'(bus.Holdover), 64'd0);
        chk("t4_tsv", 64'(bus.TsValid), 64'd1);

        // Test 5: latch handshake, table-driven
        shift_in(32'd9, 32);
        send(8'h7D);
        shift_in(32'd10, 32);
        repeat (34) tick();
        chk("t5_pre", bus.TimeStamp, 64'h00000009_00000042);
        for (int i = 0; i < 9; i++) begin
            bus.EventCode  = tbl[i].code;
            bus.EventValid = tbl[i].valid;
            bus.LatchReq   = tbl[i].lreq;
            bus.ErrClear   = tbl[i].eclr;
            tick();
            chk($sformatf("row%0d_ts", i), bus.TimeStamp, tbl[i].ts);
            chk($sformatf("row%0d_tsv", i), 64'(bus.TsValid), 64'(tbl[i].tsv));
            chk($sformatf("row%0d_ho", i), 64'(bus.Holdover), 64'(tbl[i].ho));
            chk($sformatf("row%0d_serr", i), 64'(bus.ShiftErr), 64'(tbl[i].serr));
            chk($sformatf("row%0d_ack", i), 64'(bus.LatchAck), 64'(tbl[i].ack));
            chk($sformatf("row%0d_lts", i), bus.LatchedTs, tbl[i].lts);
        end
        bus.EventValid = 1'b0;
        bus.EventCode  = 8'h00;
        bus.LatchReq   = 1'b0;
        bus.ErrClear   = 1'b0;

        // Test 6: async reset mid-shift
        shift_in(32'hF0000000, 5);
        bus.EventCode  = 8'h71;
        bus.EventValid = 1'b1;
        @(posedge Clock);
        #3 Reset = 1'b0;
        #1 chk_zero("t6_async");
        #1 Reset = 1'b1;
        bus.EventValid = 1'b0;
        bus.EventCode  = 8'h00;
        tick();
        shift_in(32'h00000077, 32);
        chk("t6_pre_tsv", 64'(bus.TsValid), 64'd0);
        send(8'h7D);
        chk("t6_tsv", 64'(bus.TsValid), 64'd1);
        chk("t6_ts", bus.TimeStamp, 64'h00000077_00000000);
        chk("t6_serr", 64'(bus.ShiftErr), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/evr_timestamp_sequencer.md
Name: evr_timestamp_sequencer

Overview:
Controls and sequences the EVR 64-bit timestamp datapath ({seconds, fraction}) from the decoded event stream. Seconds are shifted in serially via event codes 0x70/0x71 and committed on 0x7D, which also zeroes the fraction counter. A watchdog handles a missing 0x7D. A 4-phase handshake lets software or trigger logic capture a coherent timestamp snapshot. Sits between the event decoder and timestamp consumers (FIFO tagging, register readback).

Parameters:
CLK_PER_SEC, 119000000, event clock cycles per second; fraction wrap point in holdover
WDOG_MARGIN, 1024, extra cycles beyond CLK_PER_SEC before a missing 0x7D is declared

Ports:
Clock  in  1  event clock; all logic on rising edge
Reset  in  1  asynchronous, active-low reset
EventCode  in  8  decoded event code
EventValid  in  1  EventCode qualifier, one cycle per event
LatchReq  in  1  capture request, 4-phase level
LatchAck  out  1  capture acknowledge
LatchedTs  out  64  captured timestamp
TimeStamp  out  64  live {seconds[31:0], fraction[31:0]}
TsValid  out  1  1 when SYNCED or HOLDOVER
Holdover  out  1  1 in HOLDOVER
ShiftErr  out  1  sticky: 0x7D arrived with bit count != 32
ErrClear  in  1  clears ShiftErr (single-cycle pulse)

Behaviour:
- Reset low: every output and internal register 0 immediately; state UNSYNC.
- Shifter: EventValid & 0x70 -> shreg <= {shreg[30:0],0}; 0x71 -> shift in 1 (MSB first). bitcnt increments, saturates at 33. Other codes ignored.
- Fraction: +1 every cycle, 32-bit natural wrap, except where overridden below.
- States: UNSYNC, SYNCED, HOLDOVER.
- 0x7D with bitcnt==32 (any state): seconds <= shreg, fraction <= 0, state -> SYNCED, bitcnt <= 0.
- 0x7D with bitcnt!=32: ShiftErr <= 1, bitcnt <= 0. UNSYNC: stays, fraction <= 0. SYNCED/HOLDOVER: seconds <= seconds+1, fraction <= 0, state unchanged.
- Watchdog (SYNCED): fraction == CLK_PER_SEC+WDOG_MARGIN-1 with no 0x7D that cycle -> seconds+1, fraction <= WDOG_MARGIN, state HOLDOVER.
- HOLDOVER: fraction == CLK_PER_SEC-1 -> fraction 0, seconds+1.
- UNSYNC: seconds held at 0.
- Priority: 0x7D > watchdog/holdover wrap > increment.
- TimeStamp is registered: reflects an event one cycle after EventValid.
- TsValid = state != UNSYNC; Holdover = state == HOLDOVER; both registered with state.
- Latch: LatchReq=1 and LatchAck=0 -> LatchedTs <= current TimeStamp (pre-update value if an event hits the same cycle), LatchAck=1 next cycle. LatchAck held until LatchReq=0, then cleared next cycle. LatchedTs held between captures.
- ErrClear with a simultaneous error: set wins.
- Seconds +1 wraps modulo 2^32.

Optional Feature:
EVR_TS_HOLDOVER_EN. Defined: behaviour as above. Undefined: watchdog expiry -> state UNSYNC, seconds <= 0, fraction keeps counting, TsValid=0, Holdover tied 0; HOLDOVER state absent.

Decomposition:
- Package evr_ts_pkg: EVT_SHIFT0=8'h70, EVT_SHIFT1=8'h71, EVT_SECONDS=8'h7D, state enum (UNSYNC/SYNCED/HOLDOVER), TS_W=64, SEC_W=32, BITCNT_W=6.
- One sub-module evr_ts_seconds_shifter: shreg, bitcnt, count_ok output; cleared on commit.

Test Plan (CLK_PER_SEC=100, WDOG_MARGIN=8):
1. Reset release, 32 shift events encoding 0x12345678, then 0x7D -> next cycle TimeStamp=0x12345678_00000000, TsValid=1; following cycles fraction 1, 2, 3.
2. From UNSYNC, 31 shift events then 0x7D -> ShiftErr=1, TsValid=0; ErrClear pulse -> ShiftErr=0.
3. SYNCED at seconds 5, no 0x7D -> at fraction 107: seconds=6, fraction=8, Holdover=1; 92 cycles later seconds=7, fraction=0. Without EVR_TS_HOLDOVER_EN: TsValid=0, seconds=0.
4. In HOLDOVER, valid 32-bit load 0xABCD0000 + 0x7D -> TimeStamp=0xABCD0000_00000000, Holdover=0, TsValid=1.
5. LatchReq rises in the same cycle as 0x7D with TimeStamp=0x00000009_00000042 -> LatchedTs=0x00000009_00000042, LatchAck=1 one cycle later; LatchReq low -> LatchAck=0 next cycle.
6. Reset driven low mid-shift, between clock edges -> all outputs 0 with no clock edge; after release, a 0x7D is required before TsValid=1.
